// File: rtl/counter_load_sequencer.sv
// -----------------------------------------------------------------------------
// counter_load_sequencer
//
// Upstream feeder for a 6-bit down-counter. Reload values from a producer are
// queued in a small FIFO and launched to the counter one at a time: each launch
// drives din and pulses ena for one cycle. The next launch waits for the rising
// edge of the counter's oflag, so back-to-back count runs need no producer
// timing. A zero reload is discarded, because it would never produce an oflag
// edge.
//
// Optional feature (macro COUNTER_SEQ_TIMEOUT_EN):
//   When defined, a watchdog limits the time spent waiting for oflag to
//   TIMEOUT_CYCLES cycles; on expiry timeout pulses and the sequencer returns to
//   IDLE. When undefined, no watchdog is built and timeout is tied to 0.
//
// Parameters:
//   DEPTH           FIFO entries; power of two, >= 2
//   TIMEOUT_CYCLES  watchdog limit in WAIT (used only with the macro)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   wr_en    in   push wr_data this cycle
//   wr_data  in   [5:0] reload value for the counter
//   full     out  FIFO holds DEPTH entries
//   empty    out  FIFO holds 0 entries
//   ovf      out  1-cycle pulse: a write arrived while full and was dropped
//   oflag    in   counter done flag
//   din      out  [5:0] load value to counter; held until the next launch
//   ena      out  1-cycle load strobe to counter
//   busy     out  1 while in LOAD or WAIT
//   timeout  out  1-cycle watchdog pulse; constant 0 without the macro
// -----------------------------------------------------------------------------
module counter_load_sequencer #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [5:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       ovf,
  input  logic       oflag,
  output logic [5:0] din,
  output logic       ena,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT
  } state_t;

  state_t        state;
  logic [5:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic [5:0]    head;
  logic          push;
  logic          pop;
  logic          oflag_q;
  logic          done;

  // full/empty decode straight from the registered count.
  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);

  // A same-cycle pop never makes room for a write: push looks only at full.
  assign push = wr_en && !full;
  assign pop  = (state == ST_IDLE) && !empty;
  assign head = mem[rd_ptr[AW-1:0]];

  // Only the rising edge of oflag counts as completion.
  assign done = oflag && !oflag_q;

  // NOTE: the storage array has no reset; count/empty guarantee that a slot is
  // never read before it has been written, so resetting it buys nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // NOTE: all state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      oflag_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count + PW'(push) - PW'(pop);
      ovf     <= wr_en && full;
      oflag_q <= oflag;
    end
  end

`ifdef COUNTER_SEQ_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wdog;
  logic          unused_ptr_msb;

  assign unused_ptr_msb = wr_ptr[PW-1] ^ rd_ptr[PW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      din     <= '0;
      ena     <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      wdog    <= '0;
    end else begin
      ena     <= 1'b0;
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The head entry is popped either way; zero is simply dropped.
          if (!empty && (head != 6'd0)) begin
            din   <= head;
            ena   <= 1'b1;
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          wdog  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // done has priority over an expiry in the same cycle.
          if (done) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (wdog == WW'(TIMEOUT_CYCLES - 1)) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
`else
  // Pointer MSBs only matter for wrap bookkeeping, and the watchdog limit has
  // no hardware in this build; fold both into a deliberately unused net.
  logic unused_cfg;

  assign unused_cfg = wr_ptr[PW-1] ^ rd_ptr[PW-1] ^ (^TIMEOUT_CYCLES);
  assign timeout    = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      din   <= '0;
      ena   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ena <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The head entry is popped either way; zero is simply dropped.
          if (!empty && (head != 6'd0)) begin
            din   <= head;
            ena   <= 1'b1;
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_counter_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_counter_load_sequencer
//
// Directed testbench for counter_load_sequencer. A behavioural 6-bit
// down-counter answers each ena pulse by raising oflag din cycles after it
// loads; the stall flag freezes it so the sequencer can be held in WAIT.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_counter_load_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_data = '0;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       oflag;
  logic [5:0] din;
  logic       ena;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  logic       stall = 1'b0;
  logic [5:0] m_cnt;
  logic       m_run;
  logic       timeout_seen = 1'b0;

  always #5 clk = ~clk;

  counter_load_sequencer #(
    .DEPTH          (4),
    .TIMEOUT_CYCLES (128)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .oflag   (oflag),
    .din     (din),
    .ena     (ena),
    .busy    (busy),
    .timeout (timeout)
  );

  // Down-counter model: loads din on ena, raises oflag after din more cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= '0;
      m_run <= 1'b0;
      oflag <= 1'b0;
    end else if (ena) begin
      m_cnt <= din;
      m_run <= (din != 6'd0);
      oflag <= 1'b0;
    end else if (m_run && !stall) begin
      if (m_cnt == 6'd1) begin
        oflag <= 1'b1;
        m_run <= 1'b0;
      end
      m_cnt <= m_cnt - 6'd1;
    end
  end

  always @(posedge clk) begin
    if (timeout === 1'b1) timeout_seen <= 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [5:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    tick();
    wr_en   = 1'b0;
  endtask

  // Ticks until oflag is high; n is the number of ticks taken (budget on expiry).
  task automatic wait_oflag(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (oflag !== 1'b1 && n < budget);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp += 7;
    if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (ena !== 1'b0) begin n_bad++; $display("FAIL reset_ena: got %b want 0", ena); end
    if (din !== 6'd0) begin n_bad++; $display("FAIL reset_din: got %0d want 0", din); end
    if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    rst_n = 1'b1;

    // Park the sequencer in WAIT with three entries queued, then reset.
    stall = 1'b1;
    push_one(6'd7);
    wr_en = 1'b1;
    wr_data = 6'd1; tick();
    wr_data = 6'd2; tick();
    wr_data = 6'd3; tick();
    wr_en = 1'b0;
    tick();
    n_cmp += 2;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL pre_reset_busy: got %b want 1", busy); end
    if (empty !== 1'b0) begin n_bad++; $display("FAIL pre_reset_empty: got %b want 0", empty); end
    rst_n = 1'b0;
    tick();
    n_cmp += 4;
    if (empty !== 1'b1) begin n_bad++; $display("FAIL midwait_reset_empty: got %b want 1", empty); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midwait_reset_busy: got %b want 0", busy); end
    if (ena !== 1'b0) begin n_bad++; $display("FAIL midwait_reset_ena: got %b want 0", ena); end
    if (din !== 6'd0) begin n_bad++; $display("FAIL midwait_reset_din: got %0d want 0", din); end
    rst_n = 1'b1;
    stall = 1'b0;
    begin
      int enas = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (ena === 1'b1) enas++;
      end
      n_cmp++;
      if (enas != 0) begin n_bad++; $display("FAIL post_reset_no_ena: got %0d pulses want 0", enas); end
    end
  endtask

  task automatic test_single_load();
    int n;
    push_one(6'd8);
    tick();
    n_cmp += 3;
    if (ena !== 1'b1) begin n_bad++; $display("FAIL single_ena: got %b want 1", ena); end
    if (din !== 6'd8) begin n_bad++; $display("FAIL single_din: got %0d want 8", din); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
    tick();
    n_cmp++;
    if (ena !== 1'b0) begin n_bad++; $display("FAIL single_ena_width: got %b want 0", ena); end
    wait_oflag(60, n);
    n_cmp++;
    if (n != 8) begin n_bad++; $display("FAIL single_oflag_delay: got %0d want 8", n); end
    tick();
    n_cmp += 2;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_done: got %b want 0", busy); end
    if (din !== 6'd8) begin n_bad++; $display("FAIL single_din_hold: got %0d want 8", din); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [5:0] vals [3];
    int         dly  [3];
    vals[0] = 6'd8;  vals[1] = 6'd16; vals[2] = 6'd3;
    dly[0]  = 8;     dly[1]  = 17;    dly[2]  = 4;
    wr_en = 1'b1;
    wr_data = 6'd8;  tick();
    wr_data = 6'd16; tick();
    n_cmp += 2;
    if (ena !== 1'b1) begin n_bad++; $display("FAIL chain0_ena: got %b want 1", ena); end
    if (din !== 6'd8) begin n_bad++; $display("FAIL chain0_din: got %0d want 8", din); end
    wr_data = 6'd3;  tick();
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_oflag(80, n);
      n_cmp++;
      if (n != dly[i]) begin n_bad++; $display("FAIL chain%0d_oflag_delay: got %0d want %0d", i, n, dly[i]); end
      tick();
      n_cmp++;
      if (ena !== 1'b0) begin n_bad++; $display("FAIL chain%0d_gap: got ena %b want 0", i, ena); end
      tick();
      if (i < 2) begin
        n_cmp += 2;
        if (ena !== 1'b1) begin n_bad++; $display("FAIL chain%0d_ena: got %b want 1", i + 1, ena); end
        if (din !== vals[i+1]) begin n_bad++; $display("FAIL chain%0d_din: got %0d want %0d", i + 1, din, vals[i+1]); end
      end else begin
        n_cmp += 2;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL chain_end_busy: got %b want 0", busy); end
        if (empty !== 1'b1) begin n_bad++; $display("FAIL chain_end_empty: got %b want 1", empty); end
      end
    end
  endtask

  task automatic test_full_overflow();
    logic [5:0] exp [4];
    int got;
    exp[0] = 6'd11; exp[1] = 6'd22; exp[2] = 6'd33; exp[3] = 6'd44;
    stall = 1'b1;
    push_one(6'd9);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      push_one(exp[i]);
      if (i == 2) begin
        n_cmp++;
        if (full !== 1'b0) begin n_bad++; $display("FAIL full_after3: got %b want 0", full); end
      end
    end
    n_cmp += 2;
    if (full !== 1'b1) begin n_bad++; $display("FAIL full_after4: got %b want 1", full); end
    if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_before: got %b want 0", ovf); end
    push_one(6'd63);
    n_cmp++;
    if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse: got %b want 1", ovf); end
    tick();
    n_cmp += 2;
    if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_width: got %b want 0", ovf); end
    if (full !== 1'b1) begin n_bad++; $display("FAIL full_hold: got %b want 1", full); end
    stall = 1'b0;
    got = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (ena === 1'b1) begin
        n_cmp++;
        if (got >= 4) begin
          n_bad++;
          $display("FAIL ovf_extra_launch: got din %0d want no launch", din);
        end else if (din !== exp[got]) begin
          n_bad++;
          $display("FAIL ovf_launch%0d_din: got %0d want %0d", got, din, exp[got]);
        end
        got++;
      end
    end
    n_cmp += 2;
    if (got != 4) begin n_bad++; $display("FAIL ovf_launch_count: got %0d want 4", got); end
    if (empty !== 1'b1) begin n_bad++; $display("FAIL ovf_end_empty: got %b want 1", empty); end
  endtask

  task automatic test_zero_skip();
    int n;
    wr_en = 1'b1;
    wr_data = 6'd0; tick();
    wr_data = 6'd5; tick();
    wr_en = 1'b0;
    n_cmp += 2;
    if (ena !== 1'b0) begin n_bad++; $display("FAIL zero_no_ena: got %b want 0", ena); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_no_busy: got %b want 0", busy); end
    tick();
    n_cmp += 2;
    if (ena !== 1'b1) begin n_bad++; $display("FAIL zero_then5_ena: got %b want 1", ena); end
    if (din !== 6'd5) begin n_bad++; $display("FAIL zero_then5_din: got %0d want 5", din); end
    wait_oflag(40, n);
    n_cmp++;
    if (n != 6) begin n_bad++; $display("FAIL zero_then5_delay: got %0d want 6", n); end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_end_busy: got %b want 0", busy); end
  endtask

`ifdef COUNTER_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    stall = 1'b1;
    wr_en = 1'b1;
    wr_data = 6'd20; tick();
    wr_data = 6'd30; tick();
    wr_en = 1'b0;
    tick();
    n = 0;
    do begin
      tick();
      n++;
    end while (timeout !== 1'b1 && n < 300);
    n_cmp++;
    if (n != 128) begin n_bad++; $display("FAIL timeout_delay: got %0d want 128", n); end
    tick();
    n_cmp += 3;
    if (timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_width: got %b want 0", timeout); end
    if (ena !== 1'b1) begin n_bad++; $display("FAIL timeout_next_ena: got %b want 1", ena); end
    if (din !== 6'd30) begin n_bad++; $display("FAIL timeout_next_din: got %0d want 30", din); end
    stall = 1'b0;
    wait_oflag(60, n);
    n_cmp++;
    if (n != 31) begin n_bad++; $display("FAIL timeout_resume_delay: got %0d want 31", n); end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_end_busy: got %b want 0", busy); end
  endtask
`else
  task automatic test_timeout();
    n_cmp += 2;
    if (timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_tied_now: got %b want 0", timeout); end
    if (timeout_seen !== 1'b0) begin n_bad++; $display("FAIL timeout_tied_ever: got %b want 0", timeout_seen); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_load();
    test_back_to_back();
    test_full_overflow();
    test_zero_skip();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
